// File: rtl/minimac2_tx_engine.sv
// MII transmit engine: preamble, SFD, nibble-serialised frame bytes read from
// the packet buffer, then an idle inter-frame gap closed by a one-cycle done pulse.
module minimac2_tx_engine #(
  parameter int PREAMBLE_NIBBLES = 15,
  parameter int IFG_NIBBLES      = 24
) (
  input  logic        phy_clk,
  input  logic        phy_rst,
  input  logic        start,
  input  logic [10:0] count,
  output logic        busy,
  output logic        done,
  output logic [10:0] mem_adr_o,
  input  logic [7:0]  mem_dat_i,
  output logic [3:0]  mii_txd,
  output logic        mii_tx_en
);

  localparam int MAXC = (PREAMBLE_NIBBLES > IFG_NIBBLES) ? PREAMBLE_NIBBLES : IFG_NIBBLES;
  localparam int CW   = ($clog2(MAXC + 1) > 11) ? $clog2(MAXC + 1) : 11;

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA_LO, DATA_HI, IFG} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [10:0]     n_q, n_d;
  logic [3:0]      hi_q, hi_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            en_q, en_d;
  logic [3:0]      txd_q, txd_d;
  logic [10:0]     adr_q, adr_d;
  logic [10:0]     nxt_k;

  // state_q describes what the output registers are showing in the current cycle;
  // the combinational block decides the contents of the following cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    hi_d    = hi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    en_d    = en_q;
    txd_d   = txd_q;
    adr_d   = adr_q;
    nxt_k   = cnt_q[10:0] + 11'd1;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        en_d   = 1'b0;
        txd_d  = 4'h0;
        if (start && (count != 11'd0)) begin
          state_d = PREAMBLE;
          n_d     = count;
          cnt_d   = CW'(1);
          busy_d  = 1'b1;
          en_d    = 1'b1;
          txd_d   = 4'h5;
          adr_d   = 11'd0;
        end
      end
      PREAMBLE: begin
        if (cnt_q == CW'(PREAMBLE_NIBBLES)) begin
          state_d = SFD;
          txd_d   = 4'hD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SFD: begin
        // Byte 0 has been on mem_dat_i since address 0 was presented during the preamble.
        state_d = DATA_LO;
        cnt_d   = '0;
        txd_d   = mem_dat_i[3:0];
        hi_d    = mem_dat_i[7:4];
        if (n_q > 11'd1) adr_d = 11'd1;
      end
      DATA_LO: begin
        state_d = DATA_HI;
        txd_d   = hi_q;
      end
      DATA_HI: begin
        if (cnt_q[10:0] == n_q - 11'd1) begin
          state_d = IFG;
          cnt_d   = CW'(1);
          en_d    = 1'b0;
          txd_d   = 4'h0;
        end else begin
          state_d = DATA_LO;
          cnt_d   = CW'(nxt_k);
          txd_d   = mem_dat_i[3:0];
          hi_d    = mem_dat_i[7:4];
          // Prefetch the next byte, but never step past the last valid address.
          if (({1'b0, nxt_k} + 12'd1) < {1'b0, n_q}) adr_d = nxt_k + 11'd1;
        end
      end
      IFG: begin
        if (cnt_q == CW'(IFG_NIBBLES)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge phy_clk) begin
    if (phy_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      hi_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      txd_q   <= '0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      hi_q    <= hi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= en_d;
      txd_q   <= txd_d;
      adr_q   <= adr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mii_tx_en = en_q;
  assign mii_txd   = txd_q;
  assign mem_adr_o = adr_q;

endmodule

// File: tb/tb_minimac2_tx_engine.sv
// Self-checking bench for minimac2_tx_engine: frame-level reference model built
// from the cycle timeline of a frame, table vectors, random frames and corner sequences.
module tb_minimac2_tx_engine;

  localparam int P = 15;
  localparam int G = 24;

  logic        phy_clk = 1'b0;
  logic        phy_rst;
  logic        start;
  logic [10:0] count;
  logic        busy, done, mii_tx_en;
  logic [10:0] mem_adr_o;
  logic [7:0]  mem_dat_i;
  logic [3:0]  mii_txd;

  logic [7:0]  mem [0:2047];
  int checks = 0;
  int errors = 0;

  minimac2_tx_engine #(.PREAMBLE_NIBBLES(P), .IFG_NIBBLES(G)) dut (
    .phy_clk(phy_clk), .phy_rst(phy_rst), .start(start), .count(count),
    .busy(busy), .done(done), .mem_adr_o(mem_adr_o), .mem_dat_i(mem_dat_i),
    .mii_txd(mii_txd), .mii_tx_en(mii_tx_en)
  );

  always #5 phy_clk = ~phy_clk;

  // Synchronous-read packet buffer: data appears one cycle after the address.
  always @(posedge phy_clk) mem_dat_i <= mem[mem_adr_o];

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        en;
    logic [3:0]  txd;
    logic [10:0] adr;
  } obs_t;

  typedef struct {
    int n;
    int intr_c;
    bit chain;
    int exp_done;
    int exp_ifg;
  } vec_t;

  task automatic tick();
    @(posedge phy_clk);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy; o.done = done; o.en = mii_tx_en; o.txd = mii_txd; o.adr = mem_adr_o;
    return o;
  endfunction

  // Expected outputs in cycle c of an n-byte frame accepted in cycle 0.
  function automatic obs_t model(int c, int n);
    obs_t o;
    int j, k;
    logic [7:0] b;
    o = '0;
    o.adr = 11'(n - 1);
    if (c >= 1 && c <= P) begin
      o.busy = 1'b1; o.en = 1'b1; o.txd = 4'h5; o.adr = 11'd0;
    end else if (c == P + 1) begin
      o.busy = 1'b1; o.en = 1'b1; o.txd = 4'hD; o.adr = 11'd0;
    end else if (c >= P + 2 && c <= P + 1 + 2 * n) begin
      j = c - P - 2;
      k = j / 2;
      b = mem[k];
      o.busy = 1'b1; o.en = 1'b1;
      o.txd = (j % 2 == 0) ? b[3:0] : b[7:4];
      o.adr = (k + 1 < n) ? 11'(k + 1) : 11'(n - 1);
    end else if (c >= P + 2 * n + 2 && c <= P + 2 * n + 1 + G) begin
      o.busy = 1'b1;
    end else if (c == P + 2 * n + 2 + G) begin
      o.done = 1'b1;
    end
    return o;
  endfunction

  task automatic chk(input string name, input int c, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got busy=%0b done=%0b en=%0b txd=%h adr=%0d, expected busy=%0b done=%0b en=%0b txd=%h adr=%0d",
               name, c, act.busy, act.done, act.en, act.txd, act.adr,
               exp.busy, exp.done, exp.en, exp.txd, exp.adr);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Starts a frame from the current cycle (cycle 0) and checks every cycle up to
  // and including the done cycle; returns positioned in the done cycle.
  task automatic run_frame(input string name, input int n, input int intr_c, input bit noise,
                           output int done_c, output int ifg_c, output int max_adr);
    int last;
    obs_t a;
    last = P + 2 * n + 2 + G;
    done_c = -1; ifg_c = 0; max_adr = 0;
    start = 1'b1;
    count = 11'(n);
    tick();
    start = 1'b0;
    for (int c = 1; c <= last; c++) begin
      a = sample();
      chk(name, c, a, model(c, n));
      if (a.done) done_c = c;
      if (a.busy && !a.en) ifg_c++;
      if (int'(a.adr) > max_adr) max_adr = int'(a.adr);
      if (c == last) break;
      start = (c == intr_c) || (noise && $urandom_range(0, 3) == 0);
      count = 11'($urandom_range(0, 2047));
      tick();
    end
    start = 1'b0;
  endtask

  task automatic idle_cycles(input string name, input int n, input int k);
    for (int i = 1; i <= k; i++) begin
      tick();
      chk(name, i, sample(), model(100000, n));
    end
  endtask

  initial begin
    vec_t vecs[5];
    int dc, ic, ma, n;
    obs_t z;
    z = '0;
    vecs[0] = '{1, -1, 1'b0, 43, 24};
    vecs[1] = '{4, 10, 1'b0, 49, 24};
    vecs[2] = '{2, -1, 1'b1, 45, 24};
    vecs[3] = '{2, -1, 1'b0, 45, 24};
    vecs[4] = '{3,  5, 1'b0, 47, 24};

    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA7;

    // Reset with a simultaneous start request that must be ignored.
    phy_rst = 1'b1; start = 1'b1; count = 11'd3;
    tick(); tick(); tick();
    chk("reset", 0, sample(), z);
    phy_rst = 1'b0; start = 1'b0;
    tick();
    chk("reset_release", 1, sample(), z);

    for (int v = 0; v < 5; v++) begin
      run_frame("vec", vecs[v].n, vecs[v].intr_c, 1'b0, dc, ic, ma);
      chk_int("vec_done", dc, vecs[v].exp_done);
      chk_int("vec_ifg", ic, vecs[v].exp_ifg);
      if (!vecs[v].chain) idle_cycles("vec_idle", vecs[v].n, 3);
    end
    n = 3;

    // count=0 requests are never accepted.
    start = 1'b1; count = 11'd0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      chk("count_zero", i, sample(), model(100000, n));
    end
    start = 1'b0;

    // Reset in cycle 20 of an 8-byte frame, start held alongside it.
    start = 1'b1; count = 11'd8;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      chk("rst_frame", c, sample(), model(c, 8));
      if (c < 20) tick();
    end
    phy_rst = 1'b1; start = 1'b1; count = 11'd5;
    tick();
    chk("rst_abort", 21, sample(), z);
    phy_rst = 1'b0; start = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      chk("rst_no_done", 21 + i, sample(), z);
    end

    // Random frames with random buffer contents and start/count noise while busy.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
      run_frame("rand", n, -1, 1'b1, dc, ic, ma);
      chk_int("rand_done", dc, P + 2 * n + 2 + G);
      chk_int("rand_maxadr", ma, n - 1);
      if ($urandom_range(0, 1) == 0) idle_cycles("rand_idle", n, 2);
    end
    idle_cycles("pre_big_idle", n, 2);

    // Maximum-length frame.
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
    run_frame("n2047", 2047, -1, 1'b0, dc, ic, ma);
    chk_int("n2047_done", dc, 4135);
    chk_int("n2047_maxadr", ma, 2046);
    idle_cycles("n2047_idle", 2047, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
